// File: rtl/f_stage_pkg.sv
// Shared pipeline constants: fetch address map, exception codes, next-PC select.
package f_stage_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] IM_BASE    = 32'h0000_3000;
  localparam logic [31:0] IM_LIMIT   = 32'h0000_6FFC;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Source of the next PC, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    NPC_RESET,
    NPC_HANDLER,
    NPC_EPC,
    NPC_HOLD,
    NPC_TARGET,
    NPC_SEQ
  } npc_sel_e;

  // Misaligned or outside the instruction memory window.
  function automatic logic addr_err(input logic [31:0] a,
                                    input logic [31:0] base,
                                    input logic [31:0] limit);
    return (a[1:0] != 2'b00) || (a < base) || (a > limit);
  endfunction

endpackage

// File: rtl/f_stage_if.sv
// Fetch-stage bus: D-stage control in, instruction memory, IF/ID bundle out.
interface f_stage_if;
  import f_stage_pkg::*;

  logic        stall;
  logic        req;
  logic        eret_D;
  logic [31:0] epc;
  logic        redirect_D;
  logic [31:0] target_D;
  logic        is_bj_D;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic [31:0] instr_F;
  logic [31:0] pc_F;
  logic [4:0]  excode_F;
  logic        delay_F;

  // Fetch stage side.
  modport slave (
    input  stall, req, eret_D, epc, redirect_D, target_D, is_bj_D, i_data,
    output i_addr, instr_F, pc_F, excode_F, delay_F
  );

  // Pipeline / memory side.
  modport master (
    output stall, req, eret_D, epc, redirect_D, target_D, is_bj_D, i_data,
    input  i_addr, instr_F, pc_F, excode_F, delay_F
  );
endinterface

// File: rtl/f_pc_reg.sv
// PC register with the prioritised next-PC mux.
module f_pc_reg
  import f_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = f_stage_pkg::RESET_PC,
  parameter logic [31:0] HANDLER_PC = f_stage_pkg::HANDLER_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        redirect,
  input  logic [31:0] target,
  output logic [31:0] pc
);

  npc_sel_e    sel;
  logic [31:0] pc_nxt;

  // Priority select: exception and eret both bypass stall, since they flush/leave D.
  always_comb begin
    sel = NPC_SEQ;
    if (reset)         sel = NPC_RESET;
    else if (req)      sel = NPC_HANDLER;
    else if (eret)     sel = NPC_EPC;
    else if (stall)    sel = NPC_HOLD;
    else if (redirect) sel = NPC_TARGET;

    pc_nxt = pc + 32'd4;
    unique case (sel)
      NPC_RESET:   pc_nxt = RESET_PC;
      NPC_HANDLER: pc_nxt = HANDLER_PC;
      NPC_EPC:     pc_nxt = epc;
      NPC_HOLD:    pc_nxt = pc;
      NPC_TARGET:  pc_nxt = target;
      default:     pc_nxt = pc + 32'd4;
    endcase
  end

  // PC is the only architectural state in fetch; reset folds into the mux.
  always_ff @(posedge clk) begin
    pc <= pc_nxt;
  end

endmodule

// File: rtl/f_stage.sv
// Instruction fetch: PC, fetch address error check, eret squash, delay-slot flag.
module f_stage
  import f_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = f_stage_pkg::RESET_PC,
  parameter logic [31:0] HANDLER_PC = f_stage_pkg::HANDLER_PC,
  parameter logic [31:0] IM_BASE    = f_stage_pkg::IM_BASE,
  parameter logic [31:0] IM_LIMIT   = f_stage_pkg::IM_LIMIT,
  parameter logic [4:0]  EXC_ADEL   = f_stage_pkg::EXC_ADEL
) (
  input  logic     clk,
  input  logic     reset,
  f_stage_if.slave bus
);

  logic [31:0] pc;
  logic        adel;

  f_pc_reg #(
    .RESET_PC   (RESET_PC),
    .HANDLER_PC (HANDLER_PC)
  ) u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .stall    (bus.stall),
    .req      (bus.req),
    .eret     (bus.eret_D),
    .epc      (bus.epc),
    .redirect (bus.redirect_D),
    .target   (bus.target_D),
    .pc       (pc)
  );

  assign adel       = addr_err(pc, IM_BASE, IM_LIMIT);
  assign bus.i_addr = pc;

  // IF/ID bundle. pc_F always carries pc so CP0 gets BadVAddr/EPC even when
  // the word is squashed. The eret slot is squashed outright, so it raises no
  // AdEL; the delay flag ignores AdEL so EPC can still point at the branch.
  always_comb begin
    bus.pc_F     = pc;
    bus.instr_F  = bus.i_data;
    bus.excode_F = EXC_INT;
    bus.delay_F  = bus.is_bj_D & ~bus.eret_D;
    if (bus.eret_D) begin
      bus.instr_F = 32'h0;
    end else if (adel) begin
      bus.instr_F  = 32'h0;
      bus.excode_F = EXC_ADEL;
    end
  end

endmodule
